// File: rtl/mesh_term_if.sv
// Terminal endpoint for one mesh port: TX FIFO feeding the router input,
// RX FSM draining the router output FIFO into an RX FIFO with address checking.
module mesh_term_if #(
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 4,
    parameter int term_row   = 0,
    parameter int term_col   = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [pckg_sz-1:0] tx_data,
    input  logic               tx_push,
    output logic               tx_full,
    output logic [pckg_sz-1:0] data_out_i_in,
    output logic               pndng_i_in,
    input  logic               popin,
    input  logic [pckg_sz-1:0] data_out,
    input  logic               pndng,
    output logic               pop,
    output logic [pckg_sz-1:0] rx_data,
    output logic               rx_valid,
    input  logic               rx_pop,
    output logic [15:0]        err_count,
    output logic               proto_err,
    output logic               tx_drop
);

    localparam int          AW       = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam logic [AW:0] LP_DEPTH = (AW+1)'(fifo_depth);
    localparam logic [3:0]  LP_ROW   = 4'(term_row);
    localparam logic [3:0]  LP_COL   = 4'(term_col);

    typedef enum logic [1:0] {S_IDLE, S_POP, S_CAPT, S_SETTLE} rx_state_t;

    // TX FIFO
    logic [pckg_sz-1:0] r_tx_mem [fifo_depth];
    logic [AW-1:0]      r_tx_wr, r_tx_rd;
    logic [AW:0]        r_tx_cnt;
    logic               r_proto_err, r_tx_drop;
    logic               w_tx_empty, w_tx_full, w_tx_do_pop, w_tx_do_push;

    assign w_tx_empty   = (r_tx_cnt == '0);
    assign w_tx_full    = (r_tx_cnt == LP_DEPTH);
    assign w_tx_do_pop  = popin && !w_tx_empty;
    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign w_tx_do_push = tx_push && (!w_tx_full || w_tx_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < fifo_depth; i++) r_tx_mem[i] <= '0;
            r_tx_wr     <= '0;
            r_tx_rd     <= '0;
            r_tx_cnt    <= '0;
            r_proto_err <= 1'b0;
            r_tx_drop   <= 1'b0;
        end else begin
            if (w_tx_do_push) begin
                r_tx_mem[r_tx_wr] <= tx_data;
                r_tx_wr           <= r_tx_wr + AW'(1);
            end
            if (w_tx_do_pop) r_tx_rd <= r_tx_rd + AW'(1);
            if (w_tx_do_push && !w_tx_do_pop)      r_tx_cnt <= r_tx_cnt + (AW+1)'(1);
            else if (!w_tx_do_push && w_tx_do_pop) r_tx_cnt <= r_tx_cnt - (AW+1)'(1);
            if (popin && w_tx_empty)             r_proto_err <= 1'b1;
            if (tx_push && w_tx_full && !popin)  r_tx_drop   <= 1'b1;
        end
    end

    assign tx_full       = w_tx_full;
    assign pndng_i_in    = !w_tx_empty;
    assign data_out_i_in = r_tx_mem[r_tx_rd];
    assign proto_err     = r_proto_err;
    assign tx_drop       = r_tx_drop;

    // RX FSM
    rx_state_t          r_state;
    logic               r_pop;
    logic [15:0]        r_err_count;
    logic [pckg_sz-1:0] r_rx_mem [fifo_depth];
    logic [AW-1:0]      r_rx_wr, r_rx_rd;
    logic [AW:0]        r_rx_cnt;
    logic               w_rx_empty, w_rx_full, w_rx_push, w_rx_do_pop, w_misroute;

    assign w_rx_empty  = (r_rx_cnt == '0);
    assign w_rx_full   = (r_rx_cnt == LP_DEPTH);
    assign w_rx_push   = (r_state == S_CAPT);
    assign w_rx_do_pop = rx_pop && !w_rx_empty;
    assign w_misroute  = (data_out[pckg_sz-9 -: 4] != LP_ROW) ||
                         (data_out[pckg_sz-13 -: 4] != LP_COL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pop       <= 1'b0;
            r_err_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (pndng && !w_rx_full) begin
                        r_state <= S_POP;
                        r_pop   <= 1'b1;
                    end
                end
                S_POP: begin
                    r_pop   <= 1'b0;
                    r_state <= S_CAPT;
                end
                S_CAPT: begin
                    if (w_misroute && (r_err_count != '1)) r_err_count <= r_err_count + 16'd1;
                    r_state <= S_SETTLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // RX FIFO; the IDLE full-check guarantees room for the CAPT push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < fifo_depth; i++) r_rx_mem[i] <= '0;
            r_rx_wr  <= '0;
            r_rx_rd  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_mem[r_rx_wr] <= data_out;
                r_rx_wr           <= r_rx_wr + AW'(1);
            end
            if (w_rx_do_pop) r_rx_rd <= r_rx_rd + AW'(1);
            if (w_rx_push && !w_rx_do_pop)      r_rx_cnt <= r_rx_cnt + (AW+1)'(1);
            else if (!w_rx_push && w_rx_do_pop) r_rx_cnt <= r_rx_cnt - (AW+1)'(1);
        end
    end

    assign pop       = r_pop;
    assign err_count = r_err_count;
    assign rx_data   = r_rx_mem[r_rx_rd];
    assign rx_valid  = !w_rx_empty;

endmodule

// File: tb/tb_mesh_term_if.sv
// Scoreboard bench for mesh_term_if: TX/RX expectation queues, a small router
// model on the RX side, and a single checking task.
module tb_mesh_term_if;

    localparam int W = 40;

    logic         clk;
    logic         rst;
    logic [W-1:0] tx_data;
    logic         tx_push;
    logic         tx_full;
    logic [W-1:0] data_out_i_in;
    logic         pndng_i_in;
    logic         popin;
    logic [W-1:0] data_out;
    logic         pndng;
    logic         pop;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         rx_pop;
    logic [15:0]  err_count;
    logic         proto_err;
    logic         tx_drop;

    mesh_term_if #(
        .pckg_sz    (W),
        .fifo_depth (4),
        .term_row   (1),
        .term_col   (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_data       (tx_data),
        .tx_push       (tx_push),
        .tx_full       (tx_full),
        .data_out_i_in (data_out_i_in),
        .pndng_i_in    (pndng_i_in),
        .popin         (popin),
        .data_out      (data_out),
        .pndng         (pndng),
        .pop           (pop),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_pop        (rx_pop),
        .err_count     (err_count),
        .proto_err     (proto_err),
        .tx_drop       (tx_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_total = 0;
    int           n_bad   = 0;
    int           cyc     = 0;
    int           last_pop = -100;
    int           n_pops  = 0;
    int           exp_err = 0;
    logic [W-1:0] tx_q[$];
    logic [W-1:0] rtr_q[$];
    logic [W-1:0] rx_exp[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock; inputs and checks happen at the falling edge. Router model
    // serves a pop by presenting the next packet and updating pndng.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (pop === 1'b1) begin
            n_pops++;
            chk("pop_gap", 64'(cyc - last_pop >= 4), 64'd1);
            chk("pop_rx_room", 64'(rx_exp.size() < 4), 64'd1);
            chk("pop_pndng", 64'(pndng), 64'd1);
            last_pop = cyc;
            if (rtr_q.size() != 0) begin
                data_out = rtr_q.pop_front();
                rx_exp.push_back(data_out);
            end
        end
        pndng = (rtr_q.size() != 0);
    endtask

    task automatic rtr_send(input logic [W-1:0] p);
        rtr_q.push_back(p);
        if (p[31:28] != 4'd1 || p[27:24] != 4'd2) exp_err++;
    endtask

    task automatic tx_put(input logic [W-1:0] p);
        tx_data = p;
        tx_push = 1'b1;
        tx_q.push_back(p);
        tick();
        tx_push = 1'b0;
    endtask

    task automatic tx_take();
        chk("tx_head", data_out_i_in, tx_q.pop_front());
        popin = 1'b1;
        tick();
        popin = 1'b0;
    endtask

    task automatic rx_take();
        chk("rx_valid_take", 64'(rx_valid), 64'd1);
        chk("rx_data", rx_data, rx_exp.pop_front());
        rx_pop = 1'b1;
        tick();
        rx_pop = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tx_data = '0; tx_push = 1'b0; popin = 1'b0;
        data_out = '0; pndng = 1'b0; rx_pop = 1'b0;
        tick(); tick();
        chk("rst_pop", 64'(pop), 64'd0);
        chk("rst_tx_head", data_out_i_in, 64'd0);
        chk("rst_rx_data", rx_data, 64'd0);
        rst = 1'b0;
        tick();
        chk("rst_pndng_i_in", 64'(pndng_i_in), 64'd0);
        chk("rst_tx_full", 64'(tx_full), 64'd0);
        chk("rst_rx_valid", 64'(rx_valid), 64'd0);
        chk("rst_err", 64'(err_count), 64'd0);
        chk("rst_sticky", {62'd0, proto_err, tx_drop}, 64'd0);

        // TX basic flow
        tx_put(40'h0112_0000AA);
        tx_put(40'h0112_0000BB);
        chk("tx_pndng", 64'(pndng_i_in), 64'd1);
        tx_take();
        chk("tx_pndng_after1", 64'(pndng_i_in), 64'd1);
        tx_take();
        chk("tx_pndng_after2", 64'(pndng_i_in), 64'd0);

        // popin on empty
        popin = 1'b1; tick(); popin = 1'b0;
        chk("proto_err", 64'(proto_err), 64'd1);

        // TX full, drop, push+pop while full
        for (int i = 0; i < 4; i++) tx_put(40'h0112_000100 + 40'(i));
        chk("tx_full", 64'(tx_full), 64'd1);
        chk("tx_drop_pre", 64'(tx_drop), 64'd0);
        tx_data = 40'h0112_0DEAD0; tx_push = 1'b1; tick(); tx_push = 1'b0;
        chk("tx_drop", 64'(tx_drop), 64'd1);
        chk("tx_head_after_drop", data_out_i_in, tx_q[0]);
        chk("tx_head_pushpop", data_out_i_in, tx_q.pop_front());
        tx_data = 40'h0112_000200; tx_q.push_back(tx_data);
        tx_push = 1'b1; popin = 1'b1; tick(); tx_push = 1'b0; popin = 1'b0;
        chk("tx_full_pushpop", 64'(tx_full), 64'd1);
        for (int i = 0; i < 4; i++) tx_take();
        chk("tx_drained", 64'(pndng_i_in), 64'd0);
        chk("tx_not_full", 64'(tx_full), 64'd0);

        // Reset mid-transaction
        rtr_send(40'h0012_ABCDEF);
        pndng = 1'b1;
        for (int i = 0; i < 20 && pop !== 1'b1; i++) tick();
        chk("rst_wait_pop", 64'(pop), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_pop_async", 64'(pop), 64'd0);
        rtr_q.delete(); rx_exp.delete(); exp_err = 0; data_out = '0;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("rst_mid_rx_valid", 64'(rx_valid), 64'd0);
        chk("rst_mid_err", 64'(err_count), 64'd0);
        chk("rst_mid_sticky", {62'd0, proto_err, tx_drop}, 64'd0);

        // RX correct address
        n_pops = 0;
        rtr_send(40'h0012_000011);
        rtr_send(40'h0012_000022);
        for (int i = 0; i < 20; i++) tick();
        chk("rx_ok_pops", 64'(n_pops), 64'd2);
        rx_take();
        rx_take();
        chk("rx_ok_err", 64'(err_count), 64'(exp_err));
        chk("rx_ok_empty", 64'(rx_valid), 64'd0);

        // RX misroute
        rtr_send(40'h0030_000055);
        for (int i = 0; i < 12; i++) tick();
        chk("misroute_err", 64'(err_count), 64'(exp_err));
        rx_take();

        // RX backpressure
        n_pops = 0;
        for (int i = 0; i < 6; i++) rtr_send(40'h0012_000300 + 40'(i));
        for (int i = 0; i < 40; i++) tick();
        chk("bp_pops", 64'(n_pops), 64'd4);
        chk("bp_router_left", 64'(rtr_q.size()), 64'd2);
        rx_take();
        for (int i = 0; i < 30; i++) tick();
        chk("bp_one_more", 64'(n_pops), 64'd5);
        begin
            int guard = 0;
            while ((rx_exp.size() != 0 || rtr_q.size() != 0) && guard < 200) begin
                if (rx_valid) rx_take();
                else tick();
                guard++;
            end
            chk("bp_drain_timeout", 64'(guard < 200), 64'd1);
        end
        for (int i = 0; i < 8; i++) tick();
        chk("bp_final_pops", 64'(n_pops), 64'd6);
        chk("bp_final_empty", 64'(rx_valid), 64'd0);
        chk("final_err", 64'(err_count), 64'(exp_err));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
